// File: rtl/shapool_io_pkg.sv
// Shared types and width helpers for the shapool SPI front-end and job sequencer.
package shapool_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FOUND = 2'd3
  } state_t;

  localparam int JOB_BITS_DEF   = 352;
  localparam int NONCE_BITS_DEF = 32;
  localparam int CFG_BITS_DEF   = 8;

  // Bits needed to hold values 0 .. v-1.
  function automatic int clog2_f(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_rx_sync.sv
// SPI pin synchroniser: resamples sck/sdi/cs_n onto clk_in and emits registered
// one-cycle strobes for sck rise, cs fall and cs rise, aligned with the data bit.
module spi_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic sck_in,
  input  logic sdi_in,
  input  logic cs_n_in,
  output logic sdi_out,
  output logic cs_n_out,
  output logic sck_rise_out,
  output logic cs_fall_out,
  output logic cs_rise_out
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_prev;
  logic                   r_cs_prev;

  // cs_n chain resets to the idle (high) level so reset exit never looks like a frame edge.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_sck_sync   <= '0;
      r_sdi_sync   <= '0;
      r_cs_sync    <= '1;
      r_sck_prev   <= 1'b0;
      r_cs_prev    <= 1'b1;
      sdi_out      <= 1'b0;
      cs_n_out     <= 1'b1;
      sck_rise_out <= 1'b0;
      cs_fall_out  <= 1'b0;
      cs_rise_out  <= 1'b0;
    end else begin
      r_sck_sync   <= {r_sck_sync[SYNC_STAGES-2:0], sck_in};
      r_sdi_sync   <= {r_sdi_sync[SYNC_STAGES-2:0], sdi_in};
      r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_in};
      r_sck_prev   <= r_sck_sync[SYNC_STAGES-1];
      r_cs_prev    <= r_cs_sync[SYNC_STAGES-1];
      sdi_out      <= r_sdi_sync[SYNC_STAGES-1];
      cs_n_out     <= r_cs_sync[SYNC_STAGES-1];
      sck_rise_out <= r_sck_sync[SYNC_STAGES-1] & ~r_sck_prev;
      cs_fall_out  <= ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;
      cs_rise_out  <= r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
    end
  end

endmodule

// File: rtl/shapool_io_ctrl.sv
// SPI front-end and job sequencer for the shapool hashing pool.
// Build macro SHAPOOL_RESULT_READBACK_EN enables winning-nonce readback over the daisy chain.
//
//   state | meaning
//   IDLE  | pool stopped, waiting for a global frame
//   LOAD  | global frame in progress
//   RUN   | pool hashing the latched job
//   FOUND | this device won; shared ready line pulled low
module shapool_io_ctrl
  import shapool_io_pkg::*;
#(
  parameter int POOL_SIZE    = 2,
  parameter int JOB_BITS     = JOB_BITS_DEF,
  parameter int CFG_BITS     = CFG_BITS_DEF,
  parameter int NONCE_BITS   = NONCE_BITS_DEF,
  parameter int SYNC_STAGES  = 2,
  parameter int LED_DIV_LOG2 = 22
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  sck0_in,
  input  logic                  sdi0_in,
  input  logic                  cs0_n_in,
  input  logic                  sck1_in,
  input  logic                  sdi1_in,
  input  logic                  cs1_n_in,
  output logic                  sdo1_out,
  input  logic                  ready_n_in,
  output logic                  ready_n_oe_out,
  output logic [JOB_BITS-1:0]   job_out,
  output logic [CFG_BITS-1:0]   cfg_out,
  output logic                  start_out,
  output logic                  halt_out,
  input  logic                  pool_success_in,
  input  logic [NONCE_BITS-1:0] pool_nonce_in,
  input  logic                  pool_done_in,
  output logic                  frame_err_out,
  output logic                  status_led_n_out
);

  localparam int DAISY_BITS       = CFG_BITS + NONCE_BITS;
  localparam int CNT_W            = clog2_f(JOB_BITS + 2);
  localparam int unused_pool_size = POOL_SIZE;

  logic w_sdi0, w_cs0_n, w_sck0_rise, w_cs0_fall, w_cs0_rise;
  logic w_sdi1, w_unused_cs1_n, w_sck1_rise, w_cs1_fall, w_cs1_rise;
  logic w_frame_good;
  logic w_rdy_n;

  state_t r_state, w_state_nxt;
  logic   w_start_nxt, w_halt_nxt;

  logic [CNT_W-1:0]        r_cnt;
  logic [JOB_BITS-1:0]     r_shift0;
  logic [DAISY_BITS-1:0]   r_daisy;
  logic [SYNC_STAGES-1:0]  r_rdy_sync;
  logic [LED_DIV_LOG2-1:0] r_led_div;

  spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .clk_in(clk_in), .reset_in(reset_in),
    .sck_in(sck0_in), .sdi_in(sdi0_in), .cs_n_in(cs0_n_in),
    .sdi_out(w_sdi0), .cs_n_out(w_cs0_n),
    .sck_rise_out(w_sck0_rise), .cs_fall_out(w_cs0_fall), .cs_rise_out(w_cs0_rise)
  );

  spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .clk_in(clk_in), .reset_in(reset_in),
    .sck_in(sck1_in), .sdi_in(sdi1_in), .cs_n_in(cs1_n_in),
    .sdi_out(w_sdi1), .cs_n_out(w_unused_cs1_n),
    .sck_rise_out(w_sck1_rise), .cs_fall_out(w_cs1_fall), .cs_rise_out(w_cs1_rise)
  );

  assign w_frame_good = (r_cnt == CNT_W'(JOB_BITS));
  assign w_rdy_n      = r_rdy_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_rdy_sync <= '1;
      r_led_div  <= '0;
    end else begin
      r_rdy_sync <= {r_rdy_sync[SYNC_STAGES-2:0], ready_n_in};
      r_led_div  <= r_led_div + LED_DIV_LOG2'(1);
    end
  end

  // Global bus: the counter saturates one past a full frame so any overrun reads as bad.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_cnt         <= '0;
      r_shift0      <= '0;
      job_out       <= '0;
      frame_err_out <= 1'b0;
    end else begin
      if (w_cs0_fall) begin
        r_cnt <= '0;
      end else if (w_sck0_rise && !w_cs0_n) begin
        r_shift0 <= {r_shift0[JOB_BITS-2:0], w_sdi0};
        if (r_cnt != CNT_W'(JOB_BITS + 1))
          r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_cs0_rise) begin
        if (w_frame_good)
          job_out <= r_shift0;
        frame_err_out <= ~w_frame_good;
      end
    end
  end

`ifdef SHAPOOL_RESULT_READBACK_EN
  logic [NONCE_BITS-1:0] r_nonce;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)
      r_nonce <= '0;
    else if (r_state == ST_RUN && pool_success_in)
      r_nonce <= pool_nonce_in;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_daisy <= '0;
      cfg_out <= '0;
    end else begin
      if (w_cs1_fall && r_state == ST_FOUND)
        r_daisy <= {cfg_out, r_nonce};
      else if (w_sck1_rise)
        r_daisy <= {r_daisy[DAISY_BITS-2:0], w_sdi1};
      if (w_cs1_rise)
        cfg_out <= r_daisy[DAISY_BITS-1 -: CFG_BITS];
    end
  end
`else
  logic w_unused_nonce;
  assign w_unused_nonce = ^pool_nonce_in;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_daisy <= '0;
      cfg_out <= '0;
    end else begin
      if (w_sck1_rise)
        r_daisy <= {r_daisy[DAISY_BITS-2:0], w_sdi1};
      if (w_cs1_rise)
        cfg_out <= r_daisy[DAISY_BITS-1 -: CFG_BITS];
    end
  end
`endif

  assign sdo1_out = r_daisy[DAISY_BITS-1];

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state   <= ST_IDLE;
      start_out <= 1'b0;
      halt_out  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      start_out <= w_start_nxt;
      halt_out  <= w_halt_nxt;
    end
  end

  // In RUN a success beats every other event so a found nonce is never dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_halt_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs0_fall)
          w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_cs0_rise) begin
          if (w_frame_good) begin
            w_state_nxt = ST_RUN;
            w_start_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        if (pool_success_in) begin
          w_state_nxt = ST_FOUND;
        end else if (w_cs0_fall) begin
          w_state_nxt = ST_LOAD;
          w_halt_nxt  = 1'b1;
        end else if (!w_rdy_n) begin
          w_state_nxt = ST_IDLE;
          w_halt_nxt  = 1'b1;
        end else if (pool_done_in) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FOUND: begin
        if (w_cs0_fall)
          w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ready_n_oe_out = (r_state == ST_FOUND);

  always_comb begin
    status_led_n_out = 1'b1;
    case (r_state)
      ST_RUN:   status_led_n_out = r_led_div[LED_DIV_LOG2-1];
      ST_FOUND: status_led_n_out = 1'b0;
      default:  status_led_n_out = 1'b1;
    endcase
  end

endmodule
